// File: rtl/spi_burst_ctrl.sv
`timescale 1ns/1ps
// spi_burst_ctrl
//   Burst controller feeding an SPI master. The host queues bytes in a TX
//   FIFO; on go_i they are sent under a single slave-select assertion with
//   one start pulse per byte. Each byte returned with the master's done tick
//   is stored in an RX FIFO that the host reads show-ahead.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   wr_en_i, wr_data_i    host push into TX FIFO
//   tx_full_o, tx_count_o TX FIFO status
//   rd_en_i, rd_data_o    host pop / head of RX FIFO
//   rx_empty_o            RX FIFO empty
//   go_i, busy_o          burst command / burst in progress
//   ss_n_o                slave select, active low
//   spi_start_o           one-cycle start pulse to the master
//   spi_din_o             byte presented to the master
//   spi_ready_i           master idle
//   spi_done_tick_i       master completion pulse
//   spi_dout_i            byte received by the master
//   rx_overflow_o         sticky: RX byte dropped (cleared by accepted go_i)
//   timeout_o             sticky: watchdog abort (cleared by accepted go_i)
module spi_burst_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     tx_full_o,
  output logic [$clog2(DEPTH):0]   tx_count_o,
  input  logic                     rd_en_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rx_empty_o,
  input  logic                     go_i,
  output logic                     busy_o,
  output logic                     ss_n_o,
  output logic                     spi_start_o,
  output logic [DATA_W-1:0]        spi_din_o,
  input  logic                     spi_ready_i,
  input  logic                     spi_done_tick_i,
  input  logic [DATA_W-1:0]        spi_dout_i,
  output logic                     rx_overflow_o,
  output logic                     timeout_o
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned WDW    = $clog2(TIMEOUT + 1);
  localparam int unsigned PC_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int unsigned PCW    = $clog2(PC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_ss_n;
  logic               r_start;
  logic [DATA_W-1:0]  r_spi_din;
  logic               r_overflow;
  logic               r_timeout;
  logic [PCW-1:0]     r_phase;
  logic [WDW-1:0]     r_wd;

  // TX FIFO storage
  logic [DATA_W-1:0]  r_tx_mem [DEPTH];
  logic [AW-1:0]      r_tx_wr;
  logic [AW-1:0]      r_tx_rd;
  logic [CW-1:0]      r_tx_count;

  // RX FIFO storage
  logic [DATA_W-1:0]  r_rx_mem [DEPTH];
  logic [AW-1:0]      r_rx_wr;
  logic [AW-1:0]      r_rx_rd;
  logic [CW-1:0]      r_rx_count;

  logic w_tx_full;
  logic w_tx_empty;
  logic w_rx_full;
  logic w_rx_empty;
  logic w_tx_push;
  logic w_tx_pop;
  logic w_tx_flush;
  logic w_rx_push;
  logic w_rx_pop;
  logic w_wait_tick;

  assign w_tx_full   = (r_tx_count == CW'(DEPTH));
  assign w_tx_empty  = (r_tx_count == '0);
  assign w_rx_full   = (r_rx_count == CW'(DEPTH));
  assign w_rx_empty  = (r_rx_count == '0);

  assign w_wait_tick = (r_state == S_WAIT) && spi_done_tick_i;
  assign w_tx_push   = wr_en_i && !w_tx_full;
  assign w_tx_pop    = (r_state == S_LOAD) && spi_ready_i;
  assign w_tx_flush  = (r_state == S_WAIT) && !spi_done_tick_i &&
                       (r_wd == WDW'(TIMEOUT - 1));
  assign w_rx_push   = w_wait_tick && !w_rx_full;
  assign w_rx_pop    = rd_en_i && !w_rx_empty;

  // ---------------------------------------------------------------- TX FIFO
  always_ff @(posedge clk_i) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wr <= r_tx_wr + AW'(1);
      end
      if (w_tx_flush) begin
        // A host byte written on the flush edge survives as the sole entry.
        r_tx_rd    <= r_tx_wr;
        r_tx_count <= CW'(w_tx_push);
      end else begin
        if (w_tx_pop) begin
          r_tx_rd <= r_tx_rd + AW'(1);
        end
        unique case ({w_tx_push, w_tx_pop})
          2'b10:   r_tx_count <= r_tx_count + CW'(1);
          2'b01:   r_tx_count <= r_tx_count - CW'(1);
          default: r_tx_count <= r_tx_count;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  always_ff @(posedge clk_i) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wr] <= spi_dout_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_wr <= r_rx_wr + AW'(1);
      end
      if (w_rx_pop) begin
        r_rx_rd <= r_rx_rd + AW'(1);
      end
      unique case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + CW'(1);
        2'b01:   r_rx_count <= r_rx_count - CW'(1);
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_ss_n     <= 1'b1;
      r_start    <= 1'b0;
      r_spi_din  <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_phase    <= '0;
      r_wd       <= '0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (go_i && !w_tx_empty) begin
            r_busy     <= 1'b1;
            r_ss_n     <= 1'b0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            r_phase    <= PCW'(1);
            // The LOAD cycle itself is the last setup cycle, so SETUP only
            // covers the first SETUP_CYC-1 cycles (none when SETUP_CYC is 1).
            if (SETUP_CYC == 1) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (r_phase == PCW'(SETUP_CYC - 1)) begin
            r_state <= S_LOAD;
          end else begin
            r_phase <= r_phase + PCW'(1);
          end
        end
        S_LOAD: begin
          if (spi_ready_i) begin
            r_spi_din <= r_tx_mem[r_tx_rd];
            r_start   <= 1'b1;
            r_wd      <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (spi_done_tick_i) begin
            if (w_rx_full) begin
              r_overflow <= 1'b1;
            end
            r_phase <= PCW'(1);
            r_state <= w_tx_empty ? S_HOLD : S_LOAD;
          end else if (w_tx_flush) begin
            r_timeout <= 1'b1;
            r_phase   <= PCW'(1);
            r_state   <= S_HOLD;
          end else begin
            r_wd <= r_wd + WDW'(1);
          end
        end
        S_HOLD: begin
          if (r_phase == PCW'(HOLD_CYC)) begin
            r_busy  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + PCW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_ss_n  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_full_o     = w_tx_full;
  assign tx_count_o    = r_tx_count;
  assign rx_empty_o    = w_rx_empty;
  assign rd_data_o     = w_rx_empty ? '0 : r_rx_mem[r_rx_rd];
  assign busy_o        = r_busy;
  assign ss_n_o        = r_ss_n;
  assign spi_start_o   = r_start;
  assign spi_din_o     = r_spi_din;
  assign rx_overflow_o = r_overflow;
  assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
`timescale 1ns/1ps
module tb_spi_burst_ctrl;

  localparam int DW  = 8;
  localparam int LAT = 20;   // master model: cycles from accepted start to done tick

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic          tx_full_o;
  logic [3:0]    tx_count_o;
  logic          rd_en_i;
  logic [DW-1:0] rd_data_o;
  logic          rx_empty_o;
  logic          go_i;
  logic          busy_o;
  logic          ss_n_o;
  logic          spi_start_o;
  logic [DW-1:0] spi_din_o;
  logic          spi_ready_i     = 1'b1;
  logic          spi_done_tick_i = 1'b0;
  logic [DW-1:0] spi_dout_i      = '0;
  logic          rx_overflow_o;
  logic          timeout_o;

  spi_burst_ctrl #(
    .DATA_W(8), .DEPTH(8), .SETUP_CYC(2), .HOLD_CYC(2), .TIMEOUT(1024)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .tx_full_o(tx_full_o), .tx_count_o(tx_count_o),
    .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .rx_empty_o(rx_empty_o),
    .go_i(go_i), .busy_o(busy_o), .ss_n_o(ss_n_o),
    .spi_start_o(spi_start_o), .spi_din_o(spi_din_o),
    .spi_ready_i(spi_ready_i), .spi_done_tick_i(spi_done_tick_i),
    .spi_dout_i(spi_dout_i),
    .rx_overflow_o(rx_overflow_o), .timeout_o(timeout_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model with MISO looped back to MOSI.
  logic          m_rst  = 1'b0;
  logic          m_mute = 1'b0;
  logic          m_busy = 1'b0;
  int            m_cnt  = 0;
  logic [DW-1:0] m_data = '0;
  always @(posedge clk) begin
    spi_done_tick_i <= 1'b0;
    if (m_rst) begin
      m_busy      <= 1'b0;
      spi_ready_i <= 1'b1;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        if (!m_mute) begin
          spi_done_tick_i <= 1'b1;
          spi_dout_i      <= m_data;
          m_busy          <= 1'b0;
          spi_ready_i     <= 1'b1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (spi_start_o) begin
      m_busy      <= 1'b1;
      spi_ready_i <= 1'b0;
      m_cnt       <= LAT;
      m_data      <= spi_din_o;
    end
  end

  // Start-pulse and done-tick monitor
  logic [DW-1:0] st_q[$];
  int            st_cyc[$];
  int            last_tick = -1;
  always @(negedge clk) begin
    if (spi_start_o) begin
      st_q.push_back(spi_din_o);
      st_cyc.push_back(cyc);
    end
    if (spi_done_tick_i) last_tick = cyc;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input string nm, input int target, input int budget);
    for (int k = 0; k < budget && st_q.size() < target; k++) step();
    chk(nm, st_q.size() >= target, 1);
  endtask

  task automatic wait_ss_high(input string nm, input int budget, output int c);
    for (int k = 0; k < budget && ss_n_o == 1'b0; k++) step();
    c = cyc;
    chk(nm, ss_n_o, 1);
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en_i   = 1'b1;
    wr_data_i = d;
    step();
    wr_en_i   = 1'b0;
  endtask

  task automatic pulse_go();
    go_i = 1'b1;
    step();
    go_i = 1'b0;
  endtask

  typedef struct {
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [3:0]    exp_cnt;
    logic          exp_full;
    logic          exp_rx_empty;
  } vec_t;

  vec_t vt[10];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base, n_go, c_end, s;

    // Table: nine writes 0x10..0x18 into an empty TX FIFO, then a read of an empty RX FIFO
    vt[0] = '{1'b1, 8'h10, 1'b0, 4'd1, 1'b0, 1'b1};
    vt[1] = '{1'b1, 8'h11, 1'b0, 4'd2, 1'b0, 1'b1};
    vt[2] = '{1'b1, 8'h12, 1'b0, 4'd3, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'h13, 1'b0, 4'd4, 1'b0, 1'b1};
    vt[4] = '{1'b1, 8'h14, 1'b0, 4'd5, 1'b0, 1'b1};
    vt[5] = '{1'b1, 8'h15, 1'b0, 4'd6, 1'b0, 1'b1};
    vt[6] = '{1'b1, 8'h16, 1'b0, 4'd7, 1'b0, 1'b1};
    vt[7] = '{1'b1, 8'h17, 1'b0, 4'd8, 1'b1, 1'b1};
    vt[8] = '{1'b1, 8'h18, 1'b0, 4'd8, 1'b1, 1'b1};
    vt[9] = '{1'b0, 8'h00, 1'b1, 4'd8, 1'b1, 1'b1};

    // ---- reset with host activity asserted
    reset_i = 1'b1; wr_en_i = 1'b1; wr_data_i = 8'h55; rd_en_i = 1'b1; go_i = 1'b1;
    step(2);
    reset_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; go_i = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_ss_n", ss_n_o, 1);
    chk("rst_start", spi_start_o, 0);
    chk("rst_din", spi_din_o, 0);
    chk("rst_tx_full", tx_full_o, 0);
    chk("rst_tx_count", tx_count_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rx_empty", rx_empty_o, 1);
    chk("rst_overflow", rx_overflow_o, 0);
    chk("rst_timeout", timeout_o, 0);
    step();
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_tx_count", tx_count_o, 0);

    // ---- two-byte burst 0xAA, 0x01
    base = st_q.size();
    push(8'hAA);
    push(8'h01);
    chk("b2_tx_count", tx_count_o, 2);
    n_go = cyc + 1;
    pulse_go();
    chk("b2_busy_after_go", busy_o, 1);
    chk("b2_ss_after_go", ss_n_o, 0);
    wait_starts("b2_first_start_seen", base + 1, 50);
    chk("b2_first_start_cycle", st_cyc[base], n_go + 2);
    wait_ss_high("b2_end_seen", 400, c_end);
    chk("b2_start_count", st_q.size() - base, 2);
    chk("b2_din0", st_q[base], 8'hAA);
    chk("b2_din1", st_q[base + 1], 8'h01);
    chk("b2_ss_rise_cycle", c_end, last_tick + 3);
    chk("b2_busy_end", busy_o, 0);
    chk("b2_rx_not_empty", rx_empty_o, 0);
    chk("b2_rx0", rd_data_o, 8'hAA);
    rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    chk("b2_rx1", rd_data_o, 8'h01);
    rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    chk("b2_rx_empty", rx_empty_o, 1);

    // ---- table-driven fill of the TX FIFO
    for (int i = 0; i < 10; i++) begin
      wr_en_i = vt[i].wr_en; wr_data_i = vt[i].wr_data; rd_en_i = vt[i].rd_en;
      step();
      wr_en_i = 1'b0; rd_en_i = 1'b0;
      chk($sformatf("vec%0d_tx_count", i), tx_count_o, vt[i].exp_cnt);
      chk($sformatf("vec%0d_tx_full", i), tx_full_o, vt[i].exp_full);
      chk($sformatf("vec%0d_rx_empty", i), rx_empty_o, vt[i].exp_rx_empty);
    end

    // ---- burst 1: 0x10..0x17 fills the RX FIFO
    base = st_q.size();
    pulse_go();
    wait_ss_high("f1_end_seen", 800, c_end);
    chk("f1_start_count", st_q.size() - base, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("f1_din%0d", i), st_q[base + i], 8'h10 + i);
    chk("f1_overflow", rx_overflow_o, 0);
    chk("f1_tx_count", tx_count_o, 0);

    // ---- burst 2: 0x20..0x27 with the RX FIFO already full
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    base = st_q.size();
    pulse_go();
    wait_ss_high("f2_end_seen", 800, c_end);
    chk("f2_start_count", st_q.size() - base, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("f2_din%0d", i), st_q[base + i], 8'h20 + i);
    chk("f2_overflow", rx_overflow_o, 1);

    // ---- burst 3: go clears the sticky flag; the byte is dropped again
    push(8'h30);
    pulse_go();
    chk("f3_overflow_cleared", rx_overflow_o, 0);
    chk("f3_busy", busy_o, 1);
    wait_ss_high("f3_end_seen", 200, c_end);
    chk("f3_overflow_again", rx_overflow_o, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rx_hold%0d", i), rd_data_o, 8'h10 + i);
      rd_en_i = 1'b1; step(); rd_en_i = 1'b0;
    end
    chk("rx_drained", rx_empty_o, 1);

    // ---- watchdog: master never ticks
    push(8'h41);
    push(8'h42);
    m_mute = 1'b1;
    base = st_q.size();
    pulse_go();
    chk("to_overflow_cleared", rx_overflow_o, 0);
    wait_starts("to_start_seen", base + 1, 50);
    s = st_cyc[base];
    step(s + 1023 - cyc);
    chk("to_before_flag", timeout_o, 0);
    chk("to_before_tx_count", tx_count_o, 1);
    step();
    chk("to_flag", timeout_o, 1);
    chk("to_tx_flushed", tx_count_o, 0);
    chk("to_ss_hold0", ss_n_o, 0);
    step();
    chk("to_ss_hold1", ss_n_o, 0);
    step();
    chk("to_ss_high", ss_n_o, 1);
    chk("to_busy_end", busy_o, 0);
    chk("to_single_start", st_q.size() - base, 1);
    m_mute = 1'b0;
    m_rst  = 1'b1; step(); m_rst = 1'b0;

    // ---- reset while waiting for a done tick in a 4-byte burst
    for (int i = 0; i < 4; i++) push(8'h51 + 8'(i));
    base = st_q.size();
    pulse_go();
    wait_starts("mr_start_seen", base + 1, 50);
    step(5);
    chk("mr_in_wait_busy", busy_o, 1);
    reset_i = 1'b1; step(); reset_i = 1'b0;
    chk("mr_ss_n", ss_n_o, 1);
    chk("mr_busy", busy_o, 0);
    chk("mr_start", spi_start_o, 0);
    chk("mr_din", spi_din_o, 0);
    chk("mr_tx_count", tx_count_o, 0);
    chk("mr_rx_empty", rx_empty_o, 1);
    chk("mr_timeout", timeout_o, 0);
    base = st_q.size();
    step(80);
    chk("mr_no_more_starts", st_q.size() - base, 0);
    chk("mr_rx_still_empty", rx_empty_o, 1);
    chk("mr_still_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Burst controller that sits directly upstream of the SPI master and feeds it. It buffers bytes written by the host in a TX FIFO. On a `go_i` command it frames them under one slave-select assertion and issues one `start` pulse per byte to the master. Each byte the master returns on its `done_tick` is captured into an RX FIFO for the host to read.

## Interface
- `DATA_W`, 8: byte width; matches the master's `din_i`/`dout` width.
- `DEPTH`, 8: entries per FIFO; power of two, at least 2.
- `SETUP_CYC`, 2: cycles with `ss_n_o` low before the first start pulse; at least 1.
- `HOLD_CYC`, 2: cycles with `ss_n_o` low after the last done tick; at least 1.
- `TIMEOUT`, 1024: maximum cycles to wait for `spi_done_tick_i`; at least 1.

Ports:
- `clk_i`  in  1  system clock; all logic on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `wr_en_i`  in  1  push `wr_data_i` into the TX FIFO.
- `wr_data_i`  in  DATA_W  TX byte.
- `tx_full_o`  out  1  TX FIFO full.
- `tx_count_o`  out  $clog2(DEPTH)+1  TX occupancy.
- `rd_en_i`  in  1  pop the RX FIFO.
- `rd_data_o`  out  DATA_W  RX FIFO head (show-ahead).
- `rx_empty_o`  out  1  RX FIFO empty.
- `go_i`  in  1  start a burst of all queued TX bytes.
- `busy_o`  out  1  burst in progress.
- `ss_n_o`  out  1  slave select, active low.
- `spi_start_o`  out  1  one-cycle start pulse to the master.
- `spi_din_o`  out  DATA_W  byte presented to the master; registered.
- `spi_ready_i`  in  1  master idle.
- `spi_done_tick_i`  in  1  master one-cycle completion pulse.
- `spi_dout_i`  in  DATA_W  received byte; valid with the done tick.
- `rx_overflow_o`  out  1  sticky: an RX byte was dropped.
- `timeout_o`  out  1  sticky: the burst was aborted by the watchdog.

## Operation

States and transitions:
- IDLE
  - `busy_o`=0, `ss_n_o`=1.
  - `go_i`=1 with `tx_count_o`>0 → SETUP. Accepting `go_i` also clears `rx_overflow_o` and `timeout_o`.
  - `go_i` with the TX FIFO empty is ignored.
  - `go_i` in any other state is ignored.
- SETUP
  - `ss_n_o`=0; counts `SETUP_CYC` cycles, then → LOAD.
- LOAD
  - Waits for `spi_ready_i`=1.
  - On that edge: registers the TX head into `spi_din_o`, pops the TX FIFO, asserts `spi_start_o` for exactly the next cycle, clears the watchdog, → WAIT.
- WAIT
  - On `spi_done_tick_i`:
    - If the RX FIFO is not full, push `spi_dout_i`.
    - If the RX FIFO is full, drop the byte and set `rx_overflow_o`.
  - Then → LOAD if the TX FIFO is non-empty, else → HOLD.
  - If the watchdog reaches `TIMEOUT` with no tick: set `timeout_o`, flush the TX FIFO, → HOLD.
- HOLD
  - `ss_n_o`=0 for `HOLD_CYC` cycles, then → IDLE with `ss_n_o`=1.

Other rules:
- `busy_o`=1 in every state except IDLE. `ss_n_o` stays low continuously from SETUP through HOLD, with no gaps between bytes.
- Host writes during a burst are legal. A byte pushed before the FSM checks for an empty TX FIFO in WAIT joins the current burst.
- `wr_en_i` while full: ignored, no state change. `rd_en_i` while empty: ignored.
- A simultaneous host push and FSM pop on the TX FIFO both take effect; the count is unchanged. A simultaneous done-tick push and `rd_en_i` pop on the RX FIFO behave the same way.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Counts saturate at 0 and `DEPTH` purely by the ignore rules above.
- A `spi_done_tick_i` outside WAIT is ignored.

## Timing
- Reset values: `busy_o`=0, `ss_n_o`=1, `spi_start_o`=0, `spi_din_o`=0, `tx_full_o`=0, `tx_count_o`=0, `rd_data_o`=0, `rx_empty_o`=1, `rx_overflow_o`=0, `timeout_o`=0. Both FIFOs are emptied.
- `reset_i` mid-burst: every output takes its reset value at the next edge. No further start pulse is issued. Queued data is lost.
- `go_i` sampled at edge N: `busy_o`=1 and `ss_n_o`=0 from N+1.
- First `spi_start_o` high in cycle N+1+SETUP_CYC when `spi_ready_i` is already 1; `spi_din_o` is valid in the same cycle.
- Done tick at edge M:
  - RX byte visible and `rx_empty_o`=0 from M+1.
  - Next start pulse at M+2 at the earliest.
  - With the TX FIFO empty: `ss_n_o` rises at M+1+HOLD_CYC.
- A TX push at edge K makes `tx_count_o` increment at K+1. `rd_data_o` updates the cycle after a pop.

## Test plan
- Reset: hold `reset_i` 2 cycles → all outputs at their reset values; `wr_en_i`, `rd_en_i` and `go_i` during reset have no effect.
- Push 0xAA, 0x01, then `go_i`, with the SPI master at dvsr 9 and MISO looped to MOSI:
  - `ss_n_o` low 2 cycles before the first pulse.
  - Exactly 2 `spi_start_o` pulses, with `spi_din_o` 0xAA then 0x01.
  - RX reads 0xAA, 0x01.
  - `ss_n_o` high 2 cycles after the 2nd tick; `busy_o`=0.
- Write 9 bytes 0x10..0x18 with no `go_i`:
  - `tx_full_o`=1 after the 8th write, `tx_count_o`=8.
  - The 9th write is ignored.
  - The following burst transmits 0x10..0x17 only.
- Run two 8-byte bursts with no RX reads:
  - `rx_overflow_o`=1 during the 2nd burst.
  - RX holds the 1st burst's 8 bytes in order.
  - A 3rd `go_i` clears the flag.
- Master model never ticks after a start → after 1024 cycles `timeout_o`=1, `tx_count_o`=0, `ss_n_o`=1 two cycles later, `busy_o`=0.
- Assert `reset_i` for 1 cycle while in WAIT of a 4-byte burst → `ss_n_o`=1 next cycle, no further `spi_start_o`, both FIFOs empty.
